// File: rtl/cmac_reset_pkg.sv
// Shared types and helpers for the CMAC reset and QPLL bring-up sequencer.
`timescale 1ns/1ps
package cmac_reset_pkg;

    typedef enum logic [2:0] {
        WAIT_PWR = 3'd0,
        PLL_RST  = 3'd1,
        PLL_LOCK = 3'd2,
        GT_RST   = 3'd3,
        GT_DONE  = 3'd4,
        CORE_RST = 3'd5,
        RUN      = 3'd6,
        FAIL     = 3'd7
    } seq_state_t;

    localparam int PLL_SEL_QPLL0 = 0;
    localparam int PLL_SEL_QPLL1 = 1;
    localparam int PLL_SEL_BOTH  = 2;

    // One shared timer must reach the longest limit used by any timed state.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/cmac_sync_bit.sv
// Two-flop synchroniser for asynchronous status inputs; reset forces the output low.
`timescale 1ns/1ps
module cmac_sync_bit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep both stages sampling the pre-edge values,
    // so the chain really is two flops deep regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cmac_reset_sequencer.sv
// QPLL/GT/CMAC reset sequencer: brings PLLs to lock with bounded retries, releases
// GT then core resets in order, and re-sequences on lock or power loss.
`timescale 1ns/1ps
module cmac_reset_sequencer
    import cmac_reset_pkg::*;
#(
    parameter int N_COMMON          = 2,
    parameter int N_LANES           = 4,
    parameter int PLL_SEL           = 0,
    parameter int QPLL_RESET_CYCLES = 64,
    parameter int LOCK_TIMEOUT      = 1000000,
    parameter int GT_DONE_TIMEOUT   = 1000000,
    parameter int SETTLE_CYCLES     = 256,
    parameter int MAX_RETRIES       = 3
) (
    input  logic                drp_clk,
    input  logic                core_drp_reset,
    input  logic                gt_powergood,
    input  logic                restart,
    input  logic [N_COMMON-1:0] qpll0lock,
    input  logic [N_COMMON-1:0] qpll1lock,
    input  logic                gt_tx_reset_done,
    input  logic                gt_rx_reset_done,
    output logic [N_COMMON-1:0] qpll0reset,
    output logic [N_COMMON-1:0] qpll1reset,
    output logic                gt_tx_reset_out,
    output logic                gt_rx_reset_out,
    output logic                tx_reset_out,
    output logic                rx_reset_out,
    output logic [N_LANES-1:0]  rx_serdes_reset_out,
    output logic                link_ready,
    output logic                seq_fail,
    output logic [2:0]          seq_state,
    output logic [3:0]          retry_count,
    output logic [7:0]          lock_loss_count
);

    localparam int TW = timer_width(QPLL_RESET_CYCLES, LOCK_TIMEOUT, GT_DONE_TIMEOUT, SETTLE_CYCLES);
    localparam logic [TW-1:0] PLL_RST_LAST = TW'(QPLL_RESET_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LIMIT   = TW'(LOCK_TIMEOUT);
    localparam logic [TW-1:0] DONE_LIMIT   = TW'(GT_DONE_TIMEOUT);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam bit USE_Q0 = (PLL_SEL != PLL_SEL_QPLL1);
    localparam bit USE_Q1 = (PLL_SEL != PLL_SEL_QPLL0);

    logic [N_COMMON-1:0] qpll0lock_sync;
    logic [N_COMMON-1:0] qpll1lock_sync;
    logic                powergood_sync;
    logic [1:0]          done_sync;

    cmac_sync_bit #(.WIDTH(N_COMMON)) u_sync_qpll0 (
        .clk(drp_clk), .rst(core_drp_reset), .d(qpll0lock), .q(qpll0lock_sync)
    );
    cmac_sync_bit #(.WIDTH(N_COMMON)) u_sync_qpll1 (
        .clk(drp_clk), .rst(core_drp_reset), .d(qpll1lock), .q(qpll1lock_sync)
    );
    cmac_sync_bit #(.WIDTH(1)) u_sync_pwr (
        .clk(drp_clk), .rst(core_drp_reset), .d(gt_powergood), .q(powergood_sync)
    );
    cmac_sync_bit #(.WIDTH(2)) u_sync_done (
        .clk(drp_clk), .rst(core_drp_reset),
        .d({gt_tx_reset_done, gt_rx_reset_done}), .q(done_sync)
    );

    seq_state_t    state_q, state_d;
    logic [TW-1:0] timer_q;
    logic [3:0]    retry_d, retry_inc;
    logic [7:0]    loss_d, loss_inc;
    logic          pll_ok, retry_exhausted;
    logic          qpll_rst_d, gt_rst_d, core_rst_d;

    // Unselected PLLs are excluded from the lock condition entirely.
    assign pll_ok          = (!USE_Q0 || (&qpll0lock_sync)) && (!USE_Q1 || (&qpll1lock_sync));
    assign retry_inc       = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;
    assign loss_inc        = (lock_loss_count == 8'hFF) ? lock_loss_count : lock_loss_count + 8'd1;
    assign retry_exhausted = (int'(retry_count) + 1) >= MAX_RETRIES;
    assign seq_state       = state_q;

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        retry_d = retry_count;
        loss_d  = lock_loss_count;
        if (restart) begin
            state_d = PLL_RST;
            retry_d = '0;
        end else if (!powergood_sync && state_q != FAIL && state_q != WAIT_PWR) begin
            state_d = WAIT_PWR;
            if (state_q == RUN) loss_d = loss_inc;
        end else begin
            case (state_q)
                WAIT_PWR: if (powergood_sync) state_d = PLL_RST;
                PLL_RST:  if (timer_q == PLL_RST_LAST) state_d = PLL_LOCK;
                PLL_LOCK: begin
                    if (pll_ok) begin
                        state_d = GT_RST;
                    end else if (timer_q == LOCK_LIMIT) begin
                        retry_d = retry_inc;
                        state_d = retry_exhausted ? FAIL : PLL_RST;
                    end
                end
                GT_RST:   state_d = GT_DONE;
                GT_DONE: begin
                    if (&done_sync) begin
                        state_d = CORE_RST;
                    end else if (timer_q == DONE_LIMIT) begin
                        retry_d = retry_inc;
                        state_d = retry_exhausted ? FAIL : GT_RST;
                    end
                end
                CORE_RST: begin
                    if (timer_q == SETTLE_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!pll_ok) begin
                        state_d = PLL_RST;
                        loss_d  = loss_inc;
                    end
                end
                FAIL:     state_d = FAIL;
                default:  state_d = WAIT_PWR;
            endcase
        end
    end

    // Reset levels are decoded from the next state and registered, so they change
    // on the same edge as seq_state and never glitch.
    always_comb begin
        qpll_rst_d = 1'b1;
        gt_rst_d   = 1'b1;
        core_rst_d = 1'b1;
        case (state_d)
            PLL_LOCK, GT_RST:  qpll_rst_d = 1'b0;
            GT_DONE, CORE_RST: begin
                qpll_rst_d = 1'b0;
                gt_rst_d   = 1'b0;
            end
            RUN: begin
                qpll_rst_d = 1'b0;
                gt_rst_d   = 1'b0;
                core_rst_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge drp_clk) begin
        if (core_drp_reset) begin
            state_q             <= WAIT_PWR;
            timer_q             <= '0;
            retry_count         <= '0;
            lock_loss_count     <= '0;
            qpll0reset          <= '1;
            qpll1reset          <= '1;
            gt_tx_reset_out     <= 1'b1;
            gt_rx_reset_out     <= 1'b1;
            tx_reset_out        <= 1'b1;
            rx_reset_out        <= 1'b1;
            rx_serdes_reset_out <= '1;
            link_ready          <= 1'b0;
            seq_fail            <= 1'b0;
        end else begin
            state_q         <= state_d;
            retry_count     <= retry_d;
            lock_loss_count <= loss_d;
            if (state_d != state_q || restart) timer_q <= '0;
            else if (timer_q != '1)            timer_q <= timer_q + 1'b1;
            qpll0reset          <= {N_COMMON{!USE_Q0 || qpll_rst_d}};
            qpll1reset          <= {N_COMMON{!USE_Q1 || qpll_rst_d}};
            gt_tx_reset_out     <= gt_rst_d;
            gt_rx_reset_out     <= gt_rst_d;
            tx_reset_out        <= core_rst_d;
            rx_reset_out        <= core_rst_d;
            rx_serdes_reset_out <= {N_LANES{core_rst_d}};
            link_ready          <= (state_d == RUN);
            seq_fail            <= (state_d == FAIL);
        end
    end

endmodule

// File: tb/tb_cmac_reset_sequencer.sv
// Scoreboard bench: directed stimulus schedules expected snapshots per cycle, a negedge
// monitor pops and compares them. Unit 0 uses QPLL0 only, unit 1 needs both PLLs.
`timescale 1ns/1ps
module tb_cmac_reset_sequencer;
    import cmac_reset_pkg::*;

    localparam int NC = 2, NL = 4, QRC = 4, LT = 100, GDT = 50, SC = 8, MR = 3;

    typedef struct packed {
        logic [2:0]    state;
        logic [3:0]    retry;
        logic [7:0]    lloss;
        logic          link_ready;
        logic          seq_fail;
        logic [NC-1:0] q0;
        logic [NC-1:0] q1;
        logic          gt_tx;
        logic          gt_rx;
        logic          tx;
        logic          rx;
        logic [NL-1:0] serdes;
    } obs_t;

    typedef struct {
        int    cyc;
        int    u;
        string name;
        obs_t  exp;
    } exp_t;

    logic          drp_clk = 1'b0;
    logic          core_drp_reset, gt_powergood, restart, tx_done, rx_done;
    logic [NC-1:0] qpll0lock, qpll1lock;

    logic [NC-1:0] q0_a, q1_a, q0_b, q1_b;
    logic          gttx_a, gtrx_a, tx_a, rx_a, link_a, fail_a;
    logic          gttx_b, gtrx_b, tx_b, rx_b, link_b, fail_b;
    logic [NL-1:0] serdes_a, serdes_b;
    logic [2:0]    st_a, st_b;
    logic [3:0]    retry_a, retry_b;
    logic [7:0]    loss_a, loss_b;
    obs_t          obs_a, obs_b;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 drp_clk = ~drp_clk;
    always @(posedge drp_clk) cyc <= cyc + 1;

    cmac_reset_sequencer #(
        .N_COMMON(NC), .N_LANES(NL), .PLL_SEL(0), .QPLL_RESET_CYCLES(QRC),
        .LOCK_TIMEOUT(LT), .GT_DONE_TIMEOUT(GDT), .SETTLE_CYCLES(SC), .MAX_RETRIES(MR)
    ) dut (
        .drp_clk(drp_clk), .core_drp_reset(core_drp_reset), .gt_powergood(gt_powergood),
        .restart(restart), .qpll0lock(qpll0lock), .qpll1lock(qpll1lock),
        .gt_tx_reset_done(tx_done), .gt_rx_reset_done(rx_done),
        .qpll0reset(q0_a), .qpll1reset(q1_a), .gt_tx_reset_out(gttx_a), .gt_rx_reset_out(gtrx_a),
        .tx_reset_out(tx_a), .rx_reset_out(rx_a), .rx_serdes_reset_out(serdes_a),
        .link_ready(link_a), .seq_fail(fail_a), .seq_state(st_a), .retry_count(retry_a),
        .lock_loss_count(loss_a)
    );

    cmac_reset_sequencer #(
        .N_COMMON(NC), .N_LANES(NL), .PLL_SEL(2), .QPLL_RESET_CYCLES(QRC),
        .LOCK_TIMEOUT(LT), .GT_DONE_TIMEOUT(GDT), .SETTLE_CYCLES(SC), .MAX_RETRIES(MR)
    ) dut_both (
        .drp_clk(drp_clk), .core_drp_reset(core_drp_reset), .gt_powergood(gt_powergood),
        .restart(restart), .qpll0lock(qpll0lock), .qpll1lock(qpll1lock),
        .gt_tx_reset_done(tx_done), .gt_rx_reset_done(rx_done),
        .qpll0reset(q0_b), .qpll1reset(q1_b), .gt_tx_reset_out(gttx_b), .gt_rx_reset_out(gtrx_b),
        .tx_reset_out(tx_b), .rx_reset_out(rx_b), .rx_serdes_reset_out(serdes_b),
        .link_ready(link_b), .seq_fail(fail_b), .seq_state(st_b), .retry_count(retry_b),
        .lock_loss_count(loss_b)
    );

    assign obs_a = {st_a, retry_a, loss_a, link_a, fail_a, q0_a, q1_a, gttx_a, gtrx_a, tx_a, rx_a, serdes_a};
    assign obs_b = {st_b, retry_b, loss_b, link_b, fail_b, q0_b, q1_b, gttx_b, gtrx_b, tx_b, rx_b, serdes_b};

    // Expected outputs straight from the state table: which resets are held in each state.
    function automatic obs_t model(input int u, input seq_state_t st, input int retry, input int ll);
        obs_t o;
        logic q_r, g_r, c_r;
        o   = '0;
        q_r = 1'b0;
        g_r = 1'b0;
        c_r = 1'b0;
        case (st)
            WAIT_PWR, PLL_RST, FAIL: begin q_r = 1'b1; g_r = 1'b1; c_r = 1'b1; end
            PLL_LOCK, GT_RST:        begin g_r = 1'b1; c_r = 1'b1; end
            GT_DONE, CORE_RST:       c_r = 1'b1;
            default: ;
        endcase
        o.state      = st;
        o.retry      = 4'(retry);
        o.lloss      = 8'(ll);
        o.link_ready = (st == RUN);
        o.seq_fail   = (st == FAIL);
        o.q0         = {NC{q_r}};
        o.q1         = (u == 0) ? {NC{1'b1}} : {NC{q_r}};
        o.gt_tx      = g_r;
        o.gt_rx      = g_r;
        o.tx         = c_r;
        o.rx         = c_r;
        o.serdes     = {NL{c_r}};
        return o;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic expect_at(input int c, input int u, input string name,
                             input seq_state_t st, input int retry, input int ll);
        exp_t e;
        e.cyc  = c;
        e.u    = u;
        e.name = name;
        e.exp  = model(u, st, retry, ll);
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge drp_clk);
            #1;
        end
    endtask

    // Monitor: every scheduled snapshot is compared on the negedge of its cycle.
    always @(negedge drp_clk) begin
        exp_t e;
        obs_t got;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d reached only at cycle %0d", e.name, e.cyc, cyc);
            end else begin
                got = (e.u == 0) ? obs_a : obs_b;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL %s (unit %0d, cycle %0d): got %h, expected %h", e.name, e.u, cyc, got, e.exp);
                end
            end
        end
    end

    initial begin
        core_drp_reset = 1'b1;
        gt_powergood   = 1'b0;
        restart        = 1'b0;
        qpll0lock      = '0;
        qpll1lock      = '0;
        tx_done        = 1'b0;
        rx_done        = 1'b0;

        // Bring-up: powergood at 10, locks 20 cycles after qpll release, done 5 later.
        expect_at(1,  0, "t1_reset",        WAIT_PWR, 0, 0);
        expect_at(3,  0, "t1_reset_hold",   WAIT_PWR, 0, 0);
        expect_at(12, 0, "t1_pwr_sync",     WAIT_PWR, 0, 0);
        expect_at(13, 0, "t1_pll_rst",      PLL_RST,  0, 0);
        expect_at(16, 0, "t1_pll_rst_end",  PLL_RST,  0, 0);
        expect_at(17, 0, "t1_pll_lock",     PLL_LOCK, 0, 0);
        expect_at(39, 0, "t1_lock_wait",    PLL_LOCK, 0, 0);
        expect_at(40, 0, "t1_gt_rst",       GT_RST,   0, 0);
        expect_at(41, 0, "t1_gt_done",      GT_DONE,  0, 0);
        expect_at(44, 0, "t1_done_wait",    GT_DONE,  0, 0);
        expect_at(45, 0, "t1_core_rst",     CORE_RST, 0, 0);
        expect_at(52, 0, "t1_settle_end",   CORE_RST, 0, 0);
        expect_at(53, 0, "t1_run",          RUN,      0, 0);
        expect_at(53, 1, "t1_run_both",     RUN,      0, 0);
        goto(3);
        core_drp_reset = 1'b0;
        goto(10);
        gt_powergood = 1'b1;
        goto(37);
        qpll0lock = '1;
        qpll1lock = '1;
        goto(42);
        tx_done = 1'b1;
        rx_done = 1'b1;

        // Locks never come: three lock timeouts, then FAIL.
        goto(55);
        expect_at(61,  0, "t2_restart",     PLL_RST,  0, 0);
        expect_at(64,  0, "t2_rst_end",     PLL_RST,  0, 0);
        expect_at(65,  0, "t2_lock",        PLL_LOCK, 0, 0);
        expect_at(165, 0, "t2_last_wait",   PLL_LOCK, 0, 0);
        expect_at(166, 0, "t2_retry1",      PLL_RST,  1, 0);
        expect_at(270, 0, "t2_lock2",       PLL_LOCK, 1, 0);
        expect_at(271, 0, "t2_retry2",      PLL_RST,  2, 0);
        expect_at(375, 0, "t2_lock3",       PLL_LOCK, 2, 0);
        expect_at(376, 0, "t2_fail",        FAIL,     3, 0);
        expect_at(376, 1, "t2_fail_both",   FAIL,     3, 0);
        expect_at(399, 0, "t2_fail_hold",   FAIL,     3, 0);
        goto(60);
        qpll0lock = '0;
        qpll1lock = '0;
        restart   = 1'b1;
        goto(61);
        restart   = 1'b0;

        // Restart out of FAIL with locks present.
        goto(395);
        expect_at(401, 0, "t5_fail_restart", PLL_RST,  0, 0);
        expect_at(405, 0, "t5_lock",         PLL_LOCK, 0, 0);
        expect_at(406, 0, "t5_gt_rst",       GT_RST,   0, 0);
        expect_at(407, 0, "t5_gt_done",      GT_DONE,  0, 0);
        expect_at(408, 0, "t5_core_rst",     CORE_RST, 0, 0);
        expect_at(415, 0, "t5_settle_end",   CORE_RST, 0, 0);
        expect_at(416, 0, "t5_run",          RUN,      0, 0);
        goto(400);
        qpll0lock = '1;
        qpll1lock = '1;
        restart   = 1'b1;
        goto(401);
        restart   = 1'b0;

        // GT done withheld: one done timeout, then restart mid-GT_DONE.
        goto(416);
        expect_at(421, 0, "t5_restart2",     PLL_RST,  0, 0);
        expect_at(427, 0, "t5_done_wait",    GT_DONE,  0, 0);
        expect_at(477, 0, "t5_done_last",    GT_DONE,  0, 0);
        expect_at(478, 0, "t5_done_timeout", GT_RST,   1, 0);
        expect_at(479, 0, "t5_done_again",   GT_DONE,  1, 0);
        expect_at(489, 0, "t5_before_rst",   GT_DONE,  1, 0);
        expect_at(490, 0, "t5_mid_restart",  PLL_RST,  0, 0);
        expect_at(505, 0, "t5_run2",         RUN,      0, 0);
        goto(420);
        tx_done = 1'b0;
        rx_done = 1'b0;
        restart = 1'b1;
        goto(421);
        restart = 1'b0;
        goto(489);
        tx_done = 1'b1;
        rx_done = 1'b1;
        restart = 1'b1;
        goto(490);
        restart = 1'b0;

        // Only QPLL0 locked: unit 1 times out once; QPLL1 lock lands on the timeout edge.
        goto(505);
        expect_at(526, 0, "t4_q0_only_run",   RUN,      0, 0);
        expect_at(615, 1, "t4_both_wait",     PLL_LOCK, 0, 0);
        expect_at(616, 1, "t4_both_timeout",  PLL_RST,  1, 0);
        expect_at(620, 1, "t4_both_lock2",    PLL_LOCK, 1, 0);
        expect_at(720, 0, "t4_q0_only_hold",  RUN,      0, 0);
        expect_at(720, 1, "t4_both_last",     PLL_LOCK, 1, 0);
        expect_at(721, 1, "t4_lock_wins",     GT_RST,   1, 0);
        expect_at(722, 1, "t4_gt_done",       GT_DONE,  1, 0);
        expect_at(723, 1, "t4_core_rst",      CORE_RST, 1, 0);
        expect_at(731, 1, "t4_run",           RUN,      0, 0);
        goto(510);
        qpll1lock = '0;
        restart   = 1'b1;
        goto(511);
        restart   = 1'b0;
        goto(718);
        qpll1lock = '1;

        // Lock loss in RUN, 300 times: count saturates at 255.
        for (int k = 0; k < 300; k++) begin
            int d;
            d = 740 + 30 * k;
            goto(d);
            expect_at(d + 2,  0, "t3_run_pre",   RUN,     0, sat(k));
            expect_at(d + 3,  0, "t3_loss",      PLL_RST, 0, sat(k + 1));
            expect_at(d + 3,  1, "t3_loss_both", PLL_RST, 0, sat(k + 1));
            expect_at(d + 23, 0, "t3_rerun",     RUN,     0, sat(k + 1));
            expect_at(d + 23, 1, "t3_rerun_both", RUN,    0, sat(k + 1));
            qpll0lock = 2'b01;
            goto(d + 10);
            qpll0lock = '1;
        end

        // core_drp_reset together with restart while in RUN: reset wins.
        goto(9740);
        expect_at(9741, 0, "t6_reset",      WAIT_PWR, 0, 0);
        expect_at(9741, 1, "t6_reset_both", WAIT_PWR, 0, 0);
        expect_at(9743, 0, "t6_resync",     WAIT_PWR, 0, 0);
        expect_at(9744, 0, "t6_pll_rst",    PLL_RST,  0, 0);
        core_drp_reset = 1'b1;
        restart        = 1'b1;
        goto(9741);
        core_drp_reset = 1'b0;
        restart        = 1'b0;

        goto(9750);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
